// File: rtl/aes_req_arbiter_if.sv
// Signal bundle between the AES request arbiter, its requesters and the AES core.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface aes_req_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);

   // Requester side
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [128*NUM_REQ-1:0] req_key;
   logic [128*NUM_REQ-1:0] req_pt;

   // Response side
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [IDW-1:0]         rsp_id;
   logic [127:0]           rsp_ct;
   logic                   rsp_err;

   // AES core side
   logic                   aes_start;
   logic [127:0]           aes_key;
   logic [127:0]           aes_plaintext;
   logic                   aes_busy;
   logic                   aes_done;
   logic [127:0]           aes_ciphertext;
   logic                   aes_fault;

   modport slave (
      input  req_valid,
      input  req_key,
      input  req_pt,
      output req_ready,
      output rsp_valid,
      input  rsp_ready,
      output rsp_id,
      output rsp_ct,
      output rsp_err,
      output aes_start,
      output aes_key,
      output aes_plaintext,
      input  aes_busy,
      input  aes_done,
      input  aes_ciphertext,
      input  aes_fault
   );

   modport master (
      output req_valid,
      output req_key,
      output req_pt,
      input  req_ready,
      input  rsp_valid,
      output rsp_ready,
      input  rsp_id,
      input  rsp_ct,
      input  rsp_err,
      input  aes_start,
      input  aes_key,
      input  aes_plaintext,
      output aes_busy,
      output aes_done,
      output aes_ciphertext,
      output aes_fault
   );

endinterface

// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter sharing one AES-128 core between NUM_REQ requesters.
// One job in flight at a time: IDLE accepts, ISSUE pulses start, WAIT watches done
// under a watchdog, RESP holds the tagged result until the response handshake.
module aes_req_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input logic              clk,
   input logic              rst,
   aes_req_arbiter_if.slave bus
);

   localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } state_e;

   state_e         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] id_q, id_d;
   logic [127:0]   key_q, key_d;
   logic [127:0]   pt_q, pt_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0] rsp_id_q, rsp_id_d;
   logic [127:0]   rsp_ct_q, rsp_ct_d;
   logic           rsp_err_q, rsp_err_d;

   logic [IDW-1:0]     grant_idx;
   logic               grant_vld;
   logic [IDW-1:0]     cand;
   logic [127:0]       sel_key;
   logic [127:0]       sel_pt;
   logic [NUM_REQ-1:0] req_ready;
   logic               aes_start;
   logic               timeout_hit;

   // Rotating priority search: first valid requester at or after ptr, wrapping around.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = IDW'((32'(ptr_q) + k) % NUM_REQ);
         if (!grant_vld && bus.req_valid[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // Select the granted requester's key and plaintext from the flat buses.
   always_comb begin
      sel_key = '0;
      sel_pt  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (grant_idx == IDW'(k)) begin
            sel_key = bus.req_key[128*k +: 128];
            sel_pt  = bus.req_pt[128*k +: 128];
         end
      end
   end

   // Ready is offered only in IDLE and only to the granted, currently valid requester.
   always_comb begin
      req_ready = '0;
      if (!rst && (state_q == StIdle) && grant_vld) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // Start is a single-cycle pulse: ISSUE lasts exactly one cycle once the core is free.
   always_comb begin
      aes_start = !rst && (state_q == StIssue) && !bus.aes_busy;
   end

   assign timeout_hit = (timer_q == TW'(TIMEOUT_CYCLES - 1));

   // Next-state logic for the job FSM, pointer, job latches, watchdog and response regs.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      id_d      = id_q;
      key_d     = key_q;
      pt_d      = pt_q;
      timer_d   = timer_q;
      rsp_id_d  = rsp_id_q;
      rsp_ct_d  = rsp_ct_q;
      rsp_err_d = rsp_err_q;
      unique case (state_q)
         StIdle: begin
            if (grant_vld) begin
               key_d   = sel_key;
               pt_d    = sel_pt;
               id_d    = grant_idx;
               ptr_d   = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: begin
            // done is deliberately ignored here; only a started job may complete.
            if (!bus.aes_busy) begin
               timer_d = '0;
               state_d = StWait;
            end
         end
         StWait: begin
            // done takes priority over the watchdog on the final cycle.
            if (bus.aes_done) begin
               rsp_ct_d  = bus.aes_ciphertext;
               rsp_err_d = bus.aes_fault;
               rsp_id_d  = id_q;
               state_d   = StResp;
            end else if (timeout_hit) begin
               rsp_ct_d  = '0;
               rsp_err_d = 1'b1;
               rsp_id_d  = id_q;
               state_d   = StResp;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StResp: begin
            if (bus.rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      rsp_valid_d = (state_d == StResp);
   end

   // State and output registers with synchronous reset; reset drops any in-flight job.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         id_q        <= '0;
         key_q       <= '0;
         pt_q        <= '0;
         timer_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_ct_q    <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         key_q       <= key_d;
         pt_q        <= pt_d;
         timer_q     <= timer_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_ct_q    <= rsp_ct_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.req_ready     = req_ready;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_id        = rsp_id_q;
   assign bus.rsp_ct        = rsp_ct_q;
   assign bus.rsp_err       = rsp_err_q;
   assign bus.aes_start     = aes_start;
   assign bus.aes_key       = key_q;
   assign bus.aes_plaintext = pt_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Scoreboard bench for aes_req_arbiter: a behavioural AES core stand-in, a requester
// driver, a monitor that pops expected responses on each response handshake, and a
// directed main sequence.
module tb_aes_req_arbiter;

   localparam int unsigned NUM_REQ        = 4;
   localparam int unsigned IDW            = 2;
   localparam int unsigned TIMEOUT_CYCLES = 64;
   localparam int unsigned CORE_LAT       = 10;

   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [127:0]   ct;
      logic           err;
   } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   aes_req_arbiter_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) bus ();

   aes_req_arbiter #(
      .NUM_REQ       (NUM_REQ),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   rsp_t        exp_q[$];

   int unsigned        cyc = 0;
   int unsigned        pend[NUM_REQ];
   int unsigned        acc_cyc = 0;
   int unsigned        start_cyc = 0;
   int unsigned        rise_cyc = 0;
   int unsigned        n_start = 0;
   logic [NUM_REQ-1:0] drv_fire;
   logic               prev_valid = 1'b0;
   logic [127:0]       k_tab[NUM_REQ];
   logic [127:0]       p_tab[NUM_REQ];

   // Core stand-in state
   int unsigned  core_cnt   = 0;
   logic         core_done  = 1'b0;
   logic         core_fault = 1'b0;
   logic         core_hang  = 1'b0;
   logic         fault_mode = 1'b0;
   logic         busy_force = 1'b0;
   logic [127:0] core_ct    = '0;
   logic [127:0] job_key    = '0;
   logic [127:0] job_pt     = '0;

   function automatic logic [127:0] core_fn(input logic [127:0] key, input logic [127:0] pt);
      if (key == FIPS_KEY && pt == FIPS_PT) return FIPS_CT;
      return key ^ {pt[63:0], pt[127:64]};
   endfunction

   function automatic logic [127:0] exp_ct(input int unsigned i);
      return core_fn(k_tab[i], p_tab[i]);
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic push_exp(input int unsigned id, input logic [127:0] ct, input logic err);
      rsp_t e;
      e.id  = IDW'(id);
      e.ct  = ct;
      e.err = err;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input string name, input int unsigned budget);
      int unsigned n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drained"}, 128'(exp_q.size() == 0), 128'(1));
      exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_req_ready"}, 128'(bus.req_ready), '0);
      check({tag, "_rsp_valid"}, 128'(bus.rsp_valid), '0);
      check({tag, "_rsp_id"}, 128'(bus.rsp_id), '0);
      check({tag, "_rsp_ct"}, bus.rsp_ct, '0);
      check({tag, "_rsp_err"}, 128'(bus.rsp_err), '0);
      check({tag, "_aes_start"}, 128'(bus.aes_start), '0);
      check({tag, "_aes_key"}, bus.aes_key, '0);
      check({tag, "_aes_plaintext"}, bus.aes_plaintext, '0);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Core stand-in: fixed latency, optional fault flag, optional hang (never done).
   always @(posedge clk) begin
      core_done  <= 1'b0;
      core_fault <= 1'b0;
      if (core_cnt != 0) begin
         core_cnt <= core_cnt - 1;
         if (core_cnt == 1 && !core_hang) begin
            core_done  <= 1'b1;
            core_fault <= fault_mode;
            core_ct    <= core_fn(job_key, job_pt);
         end
      end else if (bus.aes_start) begin
         job_key  <= bus.aes_key;
         job_pt   <= bus.aes_plaintext;
         core_cnt <= CORE_LAT;
      end
   end

   assign bus.aes_busy       = (core_cnt != 0) || busy_force;
   assign bus.aes_done       = core_done;
   assign bus.aes_fault      = core_fault;
   assign bus.aes_ciphertext = core_ct;

   // Requester driver: each requester keeps valid high while it has pending jobs.
   initial begin : req_driver
      bus.req_valid = '0;
      forever begin
         @(negedge clk);
         drv_fire = bus.req_valid & bus.req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (drv_fire[i]) begin
               acc_cyc = cyc;
               if (pend[i] != 0) pend[i]--;
            end
            bus.req_valid[i] = (pend[i] != 0);
         end
      end
   end

   // Monitor: per-cycle ready sanity, event timestamps, scoreboard pop on handshake.
   initial begin : monitor
      rsp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("req_ready_onehot",
                  128'($onehot0(bus.req_ready) && ((bus.req_ready & ~bus.req_valid) == '0)),
                  128'(1));
            if (bus.aes_start) begin
               n_start++;
               start_cyc = cyc;
            end
            if (bus.rsp_valid && !prev_valid) rise_cyc = cyc;
            if (bus.rsp_valid && bus.rsp_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_rsp: got id %0d ct %h, required no response",
                           bus.rsp_id, bus.rsp_ct);
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_id", 128'(bus.rsp_id), 128'(e.id));
                  check("rsp_ct", bus.rsp_ct, e.ct);
                  check("rsp_err", 128'(bus.rsp_err), 128'(e.err));
               end
            end
         end
         prev_valid = bus.rsp_valid;
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int unsigned  s0;
      int unsigned  n;
      logic [IDW-1:0] hold_id;
      logic [127:0] hold_ct;

      k_tab[0] = FIPS_KEY;
      p_tab[0] = FIPS_PT;
      k_tab[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      p_tab[1] = 128'h3243f6a8885a308d313198a2e0370734;
      k_tab[2] = 128'hdeadbeef0123456789abcdeffedcba98;
      p_tab[2] = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
      k_tab[3] = 128'h5555aaaa5555aaaa0000ffff0000ffff;
      p_tab[3] = 128'h13579bdf2468ace013579bdf2468ace0;
      bus.req_key   = {k_tab[3], k_tab[2], k_tab[1], k_tab[0]};
      bus.req_pt    = {p_tab[3], p_tab[2], p_tab[1], p_tab[0]};
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) pend[i] = 0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Round-robin from reset: 0,1,2,3,0,1
      s0 = n_start;
      push_exp(0, FIPS_CT, 1'b0);
      push_exp(1, exp_ct(1), 1'b0);
      push_exp(2, exp_ct(2), 1'b0);
      push_exp(3, exp_ct(3), 1'b0);
      push_exp(0, FIPS_CT, 1'b0);
      push_exp(1, exp_ct(1), 1'b0);
      pend[0] = 2;
      pend[1] = 2;
      pend[2] = 1;
      pend[3] = 1;
      wait_drain("rr", 400);
      check("rr_start_count", 128'(n_start - s0), 128'(6));

      // FIPS-197 vector on requester 0, one start pulse, start in the cycle after accept
      s0 = n_start;
      push_exp(0, FIPS_CT, 1'b0);
      pend[0] = 1;
      wait_drain("fips", 100);
      check("fips_start_count", 128'(n_start - s0), 128'(1));
      check("fips_start_latency", 128'(start_cyc - acc_cyc), 128'(0));

      // Back-pressure: response held 10 cycles, a waiting requester must not be accepted
      bus.rsp_ready = 1'b0;
      push_exp(1, exp_ct(1), 1'b0);
      pend[1] = 1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.rsp_valid && n < 100);
      check("bp_rsp_valid", 128'(bus.rsp_valid), 128'(1));
      hold_id = bus.rsp_id;
      hold_ct = bus.rsp_ct;
      check("bp_first_id", 128'(hold_id), 128'(1));
      s0 = n_start;
      push_exp(2, exp_ct(2), 1'b0);
      pend[2] = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_hold_valid", 128'(bus.rsp_valid), 128'(1));
         check("bp_hold_id", 128'(bus.rsp_id), 128'(hold_id));
         check("bp_hold_ct", bus.rsp_ct, hold_ct);
         check("bp_no_ready", 128'(bus.req_ready), '0);
      end
      check("bp_no_start", 128'(n_start - s0), 128'(0));
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      wait_drain("bp", 200);

      // Core fault reported with done
      fault_mode = 1'b1;
      push_exp(3, exp_ct(3), 1'b1);
      pend[3] = 1;
      wait_drain("fault", 100);
      fault_mode = 1'b0;

      // Core busy for 5 ISSUE cycles delays start by exactly 5
      busy_force = 1'b1;
      push_exp(2, exp_ct(2), 1'b0);
      pend[2] = 1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus.req_valid[2] && bus.req_ready[2]) && n < 50);
      check("busy_accepted", 128'(bus.req_ready[2]), 128'(1));
      @(posedge clk);
      repeat (5) @(posedge clk);
      #1;
      busy_force = 1'b0;
      wait_drain("busy", 100);
      check("busy_start_delay", 128'(start_cyc - acc_cyc), 128'(5));

      // Timeout: no done, rsp_valid TIMEOUT_CYCLES+1 cycles after start, ct 0, err 1
      core_hang = 1'b1;
      push_exp(1, '0, 1'b1);
      pend[1] = 1;
      wait_drain("timeout", 300);
      check("timeout_latency", 128'(rise_cyc - start_cyc), 128'(TIMEOUT_CYCLES + 1));
      core_hang = 1'b0;
      push_exp(1, exp_ct(1), 1'b0);
      pend[1] = 1;
      wait_drain("after_timeout", 100);

      // Reset during WAIT drops the job; the late done must not produce a response
      s0 = n_start;
      pend[3] = 1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (n_start == s0 && n < 50);
      check("midwait_started", 128'(n_start - s0), 128'(1));
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_outputs_zero("midwait");
      s0 = n_start;
      repeat (20) @(negedge clk);
      check("midwait_no_start", 128'(n_start - s0), 128'(0));
      check("midwait_no_rsp", 128'(bus.rsp_valid), '0);

      // Requesters 2 and 0 together after reset: pointer is 0, so 0 first
      push_exp(0, FIPS_CT, 1'b0);
      push_exp(2, exp_ct(2), 1'b0);
      pend[0] = 1;
      pend[2] = 1;
      wait_drain("post_reset", 200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
